// File: rtl/tstate_seq_pkg.sv
// tstate_seq_pkg: shared CPU timing types and constants for the T-state sequencer, decoder and microcode stages
package tstate_seq_pkg;
  localparam int T_MAX_DEFAULT = 7;
  typedef enum logic [1:0] {
    HALTED    = 2'd0,
    RUNNING   = 2'd1,
    STEP_HOLD = 2'd2
  } seq_state_e;
  function automatic logic [2:0] eff_last(input logic [2:0] last, input logic [2:0] t_max);
    return (last > t_max) ? t_max : last;
  endfunction
endpackage

// File: rtl/tstate_seq_step_edge.sv
// step_edge: rising-edge detector on the synchronous single-step request
module step_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);
  logic d_q;
  assign rise = d & ~d_q;
  // keep last cycle's request level so a held request fires only once
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) d_q <= 1'b0;
    else d_q <= d;
endmodule

// File: rtl/tstate_seq.sv
// tstate_seq: T-state sequencer with wait stalls, early end, halt at instruction boundary and single-step
module tstate_seq
  import tstate_seq_pkg::*;
#(
  parameter int T_MAX = T_MAX_DEFAULT
) (
  input  logic       Clk,
  input  logic       nClr,
  input  logic       Run,
  input  logic       Halt,
  input  logic       Wait,
  input  logic       EndEarly,
  input  logic [2:0] Last,
  input  logic       StepMode,
  input  logic       StepReq,
  output logic [2:0] State,
  output logic       En,
  output logic       InstrDone,
  output logic       Busy
);
  seq_state_e fsm_q, fsm_d;
  logic [2:0] state_q, state_d;
  logic       done_q, done_d;
  logic       busy_q, busy_d;
  logic       halt_q, halt_d;
  logic       step_rise;
  logic [2:0] el;
  logic       term;
  logic       adv;

  step_edge u_step_edge (
    .clk  (Clk),
    .rst_n(nClr),
    .d    (StepReq),
    .rise (step_rise)
  );

  assign State     = state_q;
  assign En        = busy_q;
  assign Busy      = busy_q;
  assign InstrDone = done_q;

  // next-state: advance/wrap the T-state, latch halt requests, stop only at a terminal advance
  always_comb begin
    el      = eff_last(Last, 3'(T_MAX));
    term    = (state_q >= el) | EndEarly;
    adv     = ~Wait & ((fsm_q == RUNNING) | ((fsm_q == STEP_HOLD) & StepMode & step_rise));
    fsm_d   = fsm_q;
    state_d = state_q;
    done_d  = 1'b0;
    halt_d  = halt_q | Halt;
    if (fsm_q == HALTED) begin
      state_d = 3'd0;
      halt_d  = 1'b0;
      fsm_d   = (Run & ~Halt) ? RUNNING : HALTED;
    end else if ((fsm_q == STEP_HOLD) & ~StepMode) begin
      fsm_d = RUNNING;
    end else if (adv) begin
      state_d = term ? 3'd0 : 3'(state_q + 3'd1);
      done_d  = term;
      fsm_d   = (term & (halt_q | Halt)) ? HALTED : StepMode ? STEP_HOLD : RUNNING;
      halt_d  = (fsm_d == HALTED) ? 1'b0 : halt_d;
    end
    busy_d = fsm_d != HALTED;
  end

  // register FSM state and every output; reset abandons any instruction in flight
  always_ff @(posedge Clk or negedge nClr)
    if (!nClr) begin
      fsm_q   <= HALTED;
      state_q <= 3'd0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      halt_q  <= halt_d;
    end
endmodule

// File: tb/tb_tstate_seq.sv
// tb_tstate_seq: directed checks of the T-state sequencer against hand-computed output vectors
module tb_tstate_seq;
  logic       Clk = 1'b0;
  logic       nClr = 1'b1;
  logic       Run = 1'b0, Halt = 1'b0, Wait = 1'b0, EndEarly = 1'b0;
  logic [2:0] Last = 3'd4;
  logic       StepMode = 1'b0, StepReq = 1'b0;
  logic [2:0] State;
  logic       En, InstrDone, Busy;
  logic [5:0] obs;
  int         total = 0;
  int         bad = 0;

  tstate_seq dut (
    .Clk      (Clk),
    .nClr     (nClr),
    .Run      (Run),
    .Halt     (Halt),
    .Wait     (Wait),
    .EndEarly (EndEarly),
    .Last     (Last),
    .StepMode (StepMode),
    .StepReq  (StepReq),
    .State    (State),
    .En       (En),
    .InstrDone(InstrDone),
    .Busy     (Busy)
  );

  assign obs = {State, En, InstrDone, Busy};

  always #5 Clk = ~Clk;

  function automatic logic [5:0] ex(input int st, input bit en, input bit dn, input bit bs);
    return {3'(st), en, dn, bs};
  endfunction

  task automatic chk(input string tag, input logic [5:0] got, input logic [5:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got st=%0d en=%b dn=%b bs=%b want st=%0d en=%b dn=%b bs=%b", tag,
               got[5:3], got[2], got[1], got[0], want[5:3], want[2], want[1], want[0]);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    #2 nClr = 1'b0;
    #1 chk("rst_async", obs, ex(0, 0, 0, 0));
    step();
    chk("rst_hold", obs, ex(0, 0, 0, 0));
    nClr = 1'b1;
    step();
    chk("idle_wait_run", obs, ex(0, 0, 0, 0));
    Run = 1'b1;
    step();
    chk("start_s0", obs, ex(0, 1, 0, 1));
    Run = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk($sformatf("last4_s%0d", i), obs, ex(i, 1, 0, 1));
    end
    step();
    chk("last4_wrap", obs, ex(0, 1, 1, 1));
    step();
    chk("last4_next", obs, ex(1, 1, 0, 1));
    Last = 3'd7;
    step();
    chk("l7_s2", obs, ex(2, 1, 0, 1));
    Wait = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("wait_hold%0d", i), obs, ex(2, 1, 0, 1));
    end
    Wait = 1'b0;
    for (int i = 3; i <= 7; i++) begin
      step();
      chk($sformatf("l7_s%0d", i), obs, ex(i, 1, 0, 1));
    end
    step();
    chk("l7_wrap", obs, ex(0, 1, 1, 1));
    Last = 3'd5;
    step();
    chk("ee_s1", obs, ex(1, 1, 0, 1));
    EndEarly = 1'b1;
    Wait = 1'b1;
    step();
    chk("ee_wait_hold", obs, ex(1, 1, 0, 1));
    Wait = 1'b0;
    step();
    chk("ee_wrap", obs, ex(0, 1, 1, 1));
    EndEarly = 1'b0;
    Last = 3'd7;
    for (int i = 1; i <= 3; i++) step();
    chk("shrink_s3", obs, ex(3, 1, 0, 1));
    Last = 3'd2;
    step();
    chk("shrink_wrap", obs, ex(0, 1, 1, 1));
    Last = 3'd3;
    step();
    chk("halt_s1", obs, ex(1, 1, 0, 1));
    Halt = 1'b1;
    step();
    Halt = 1'b0;
    chk("halt_s2", obs, ex(2, 1, 0, 1));
    step();
    chk("halt_s3", obs, ex(3, 1, 0, 1));
    step();
    chk("halt_enter", obs, ex(0, 0, 1, 0));
    step();
    chk("halt_done_once", obs, ex(0, 0, 0, 0));
    Run = 1'b1;
    Halt = 1'b1;
    step();
    chk("run_halt_stay", obs, ex(0, 0, 0, 0));
    Halt = 1'b0;
    StepMode = 1'b1;
    Last = 3'd7;
    step();
    chk("sm_start", obs, ex(0, 1, 0, 1));
    Run = 1'b0;
    step();
    chk("sm_first_adv", obs, ex(1, 1, 0, 1));
    step();
    chk("sm_hold", obs, ex(1, 1, 0, 1));
    StepReq = 1'b1;
    step();
    chk("sm_edge1", obs, ex(2, 1, 0, 1));
    step();
    chk("sm_held_hi_a", obs, ex(2, 1, 0, 1));
    step();
    chk("sm_held_hi_b", obs, ex(2, 1, 0, 1));
    StepReq = 1'b0;
    step();
    chk("sm_low", obs, ex(2, 1, 0, 1));
    StepReq = 1'b1;
    step();
    chk("sm_edge2", obs, ex(3, 1, 0, 1));
    #2 nClr = 1'b0;
    #1 chk("rst_mid", obs, ex(0, 0, 0, 0));
    step();
    nClr = 1'b1;
    StepReq = 1'b0;
    step();
    chk("post_rst_idle", obs, ex(0, 0, 0, 0));
    Run = 1'b1;
    step();
    Run = 1'b0;
    step();
    chk("sm2_s1", obs, ex(1, 1, 0, 1));
    StepMode = 1'b0;
    step();
    chk("sm_exit_noadv", obs, ex(1, 1, 0, 1));
    step();
    chk("sm_exit_run", obs, ex(2, 1, 0, 1));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
